// File: rtl/poly_eval_seq.sv
// Sequential multivariate polynomial evaluator over a programmable term table.
// One modular multiply per cycle; valid/ready on operands and result.
module poly_eval_seq #(
    parameter int NUM_IN    = 3,
    parameter int IN_W      = 8,
    parameter int OUT_W     = 24,
    parameter int MAX_TERMS = 32,
    parameter int EXP_W     = 3,
    localparam int AW       = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1,
    localparam int NW       = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_result,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [OUT_W-1:0]        cfg_coef,
    input  logic [NUM_IN*EXP_W-1:0] cfg_exp,
    input  logic                    cfg_num_we,
    input  logic [NW-1:0]           cfg_num,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE,
        TERM,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_IN*IN_W-1:0]    x_q, x_d;
    logic [OUT_W-1:0]          acc_q, acc_d;
    logic [OUT_W-1:0]          prod_q, prod_d;
    logic [OUT_W-1:0]          res_q, res_d;
    logic [AW-1:0]             t_q, t_d;
    logic [EXP_W-1:0]          cnt_q [NUM_IN];
    logic [EXP_W-1:0]          cnt_d [NUM_IN];
    logic [EXP_W-1:0]          cnt_dec [NUM_IN];

    logic [OUT_W-1:0]          coef_q [MAX_TERMS];
    logic [NUM_IN*EXP_W-1:0]   exp_q [MAX_TERMS];
    logic [NW-1:0]             num_q;

    logic                      idle;
    logic [NW-1:0]             num_sat;
    logic [NW-1:0]             eff_num;
    logic                      found;
    logic                      more;
    logic [IN_W-1:0]           xs;
    logic [OUT_W-1:0]          mul_res;
    logic                      last_term;

    assign idle       = (state_q == IDLE);
    assign in_ready   = idle;
    assign busy       = !idle;
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;

    assign num_sat = (cfg_num > NW'(MAX_TERMS)) ? NW'(MAX_TERMS) : cfg_num;
    // A count written in the accepting cycle must steer the IDLE exit
    assign eff_num = cfg_num_we ? num_sat : num_q;

    assign mul_res   = prod_q * OUT_W'(xs);
    assign last_term = (NW'(t_q) + NW'(1)) == num_q;

    always_comb begin
        found = 1'b0;
        more  = 1'b0;
        xs    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cnt_dec[k] = cnt_q[k];
            if (!found && cnt_q[k] != '0) begin
                found      = 1'b1;
                xs         = x_q[k*IN_W +: IN_W];
                cnt_dec[k] = cnt_q[k] - EXP_W'(1);
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (cnt_dec[k] != '0) more = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        res_d   = res_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d   = in_data;
                    acc_d = '0;
                    t_d   = '0;
                    if (eff_num == '0) begin
                        res_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = TERM;
                    end
                end
            end
            TERM: begin
                prod_d = coef_q[t_q];
                for (int k = 0; k < NUM_IN; k++) begin
                    cnt_d[k] = exp_q[t_q][k*EXP_W +: EXP_W];
                end
                state_d = (exp_q[t_q] == '0) ? ACC : MUL;
            end
            MUL: begin
                prod_d = mul_res;
                cnt_d  = cnt_dec;
                if (!more) state_d = ACC;
            end
            ACC: begin
                acc_d = acc_q + prod_q;
                if (last_term) begin
                    res_d   = acc_q + prod_q;
                    state_d = DONE;
                end else begin
                    t_d     = t_q + AW'(1);
                    state_d = TERM;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            t_q     <= '0;
            for (int k = 0; k < NUM_IN; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
        end
    end

    // Table is only writable while idle so a running evaluation sees a fixed polynomial
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q <= '0;
            for (int i = 0; i < MAX_TERMS; i++) begin
                coef_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else if (idle) begin
            if (cfg_we && (int'(cfg_addr) < MAX_TERMS)) begin
                coef_q[cfg_addr] <= cfg_coef;
                exp_q[cfg_addr]  <= cfg_exp;
            end
            if (cfg_num_we) num_q <= num_sat;
        end
    end

endmodule
